// File: rtl/axis_to_video_out.sv
// axis_to_video_out
//   Converts an AXI4-Stream pixel stream (tuser = start of frame, tlast = end of line) into a
//   parallel video interface with frame-valid / line-valid qualifiers. Incoming beats go into a
//   small FIFO. A two-state timing generator (StIdle / StRun) locks onto the first tuser beat,
//   then sweeps h/v counters over a fixed blanking + active raster.
//
// Ports
//   pclk, resetn                    pixel clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready      input pixel stream (tready registered: FIFO not full)
//   s_axis_tuser, s_axis_tlast      start-of-frame / end-of-line markers
//   FV, LV, D_OUT                   frame valid, line valid, pixel data (1-cycle latency)
//   err_sof, err_eol                single-cycle error pulses on marker mismatches
//   underflow                       sticky: FIFO ran dry during an active pixel
//   sof_err_cnt, eol_err_cnt        saturating error pulse counters (only with AXIS_ERR_CNT_EN)
//
// Build option: define AXIS_ERR_CNT_EN to add the two 16-bit error counters.
module axis_to_video_out #(
  parameter int unsigned ACTIVE_PIX   = 640,
  parameter int unsigned ACTIVE_LINES = 480,
  parameter int unsigned H_B_PORCH    = 120,
  parameter int unsigned H_F_PORCH    = 200,
  parameter int unsigned V_B_PORCH    = 120,
  parameter int unsigned V_F_PORCH    = 100,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
`ifdef AXIS_ERR_CNT_EN
  output logic [15:0] sof_err_cnt,
  output logic [15:0] eol_err_cnt,
`endif
  output logic        FV,
  output logic        LV,
  output logic [15:0] D_OUT,
  output logic        err_sof,
  output logic        err_eol,
  output logic        underflow
);

  localparam int unsigned H_TOTAL = H_B_PORCH + ACTIVE_PIX + H_F_PORCH;
  localparam int unsigned V_TOTAL = V_B_PORCH + ACTIVE_LINES + V_F_PORCH;
  // One spare code so the exclusive end-of-active bounds always fit.
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [HW-1:0] HLast     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActStart = HW'(H_B_PORCH);
  localparam logic [HW-1:0] HActEnd   = HW'(H_B_PORCH + ACTIVE_PIX);
  localparam logic [HW-1:0] HActLast  = HW'(H_B_PORCH + ACTIVE_PIX - 1);
  localparam logic [VW-1:0] VLast     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActStart = VW'(V_B_PORCH);
  localparam logic [VW-1:0] VActEnd   = VW'(V_B_PORCH + ACTIVE_LINES);
  localparam logic [CW-1:0] FifoFull  = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // ---------------------------------------------------------------------------------------------
  // Input FIFO: entry = {tuser, tlast, tdata}
  // ---------------------------------------------------------------------------------------------
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tready_q, tready_d;
  logic          push, pop, fifo_empty;
  logic [17:0]   head;

  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // tready is low whenever the FIFO is full, so push never coincides with a full FIFO.
  assign push       = s_axis_tvalid & tready_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    tready_d = (count_d != FifoFull);
  end

  // Storage needs no reset: pointers and count define which entries are valid.
  always_ff @(posedge pclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end

  // ---------------------------------------------------------------------------------------------
  // Timing generator and output stage
  // ---------------------------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          uf_frame_q, uf_frame_d;  // current frame has underflowed: output zeros, no pops
  logic          underflow_q, underflow_d;
  logic          fv_q, fv_d, lv_q, lv_d;
  logic [15:0]   dout_q, dout_d;
  logic          err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic          act_row, act_pix, first_pix;

  assign act_row   = (state_q == StRun) && (v_q >= VActStart) && (v_q < VActEnd);
  assign act_pix   = act_row && (h_q >= HActStart) && (h_q < HActEnd);
  assign first_pix = (v_q == VActStart) && (h_q == HActStart);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    pop         = 1'b0;
    uf_frame_d  = uf_frame_q;
    underflow_d = underflow_q;
    fv_d        = 1'b0;
    lv_d        = 1'b0;
    dout_d      = '0;
    err_sof_d   = 1'b0;
    err_eol_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Drop beats until a start-of-frame beat reaches the head; keep that one for pixel 0.
        if (!fifo_empty) begin
          if (head[17]) begin
            state_d = StRun;
            h_d     = '0;
            v_d     = '0;
          end else begin
            pop = 1'b1;
          end
        end
      end
      StRun: begin
        fv_d = act_row;
        lv_d = act_pix;
        if (act_pix && !uf_frame_q) begin
          if (fifo_empty) begin
            uf_frame_d  = 1'b1;
            underflow_d = 1'b1;
          end else begin
            pop       = 1'b1;
            dout_d    = head[15:0];
            err_eol_d = head[16] != (h_q == HActLast);
            err_sof_d = head[17] && !first_pix;
          end
        end
        if (h_q == HLast) begin
          h_d = '0;
          if (v_q == VLast) begin
            state_d    = StIdle;
            v_d        = '0;
            uf_frame_d = 1'b0;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      uf_frame_q  <= 1'b0;
      underflow_q <= 1'b0;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      dout_q      <= '0;
      err_sof_q   <= 1'b0;
      err_eol_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tready_q    <= tready_d;
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      uf_frame_q  <= uf_frame_d;
      underflow_q <= underflow_d;
      fv_q        <= fv_d;
      lv_q        <= lv_d;
      dout_q      <= dout_d;
      err_sof_q   <= err_sof_d;
      err_eol_q   <= err_eol_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign FV            = fv_q;
  assign LV            = lv_q;
  assign D_OUT         = dout_q;
  assign err_sof       = err_sof_q;
  assign err_eol       = err_eol_q;
  assign underflow     = underflow_q;

`ifdef AXIS_ERR_CNT_EN
  logic [15:0] sof_cnt_q, sof_cnt_d, eol_cnt_q, eol_cnt_d;

  // Count the registered pulses; hold at all-ones instead of wrapping.
  always_comb begin
    sof_cnt_d = sof_cnt_q;
    eol_cnt_d = eol_cnt_q;
    if (err_sof_q && (sof_cnt_q != 16'hFFFF)) sof_cnt_d = sof_cnt_q + 16'd1;
    if (err_eol_q && (eol_cnt_q != 16'hFFFF)) eol_cnt_d = eol_cnt_q + 16'd1;
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      sof_cnt_q <= '0;
      eol_cnt_q <= '0;
    end else begin
      sof_cnt_q <= sof_cnt_d;
      eol_cnt_q <= eol_cnt_d;
    end
  end

  assign sof_err_cnt = sof_cnt_q;
  assign eol_err_cnt = eol_cnt_q;
`endif

endmodule

// File: doc/axis_to_video_out.md
AXIS_TO_VIDEO_OUT -- requirements
Module: axis_to_video_out

Interface
REQ-001 SHALL have parameter ACTIVE_PIX, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter ACTIVE_LINES, default 480, meaning active lines per frame.
REQ-003 SHALL have parameters H_B_PORCH 120, H_F_PORCH 200, V_B_PORCH 120, V_F_PORCH 100, meaning blanking lengths in pclk cycles / lines.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning input buffer depth (power of 2, >=2).
REQ-005 SHALL have port pclk, input, 1, the only clock.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_axis_tdata (input, 16, pixel), s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tuser (input, 1, start of frame), s_axis_tlast (input, 1, end of line).
REQ-008 SHALL have ports FV (output, 1, frame valid), LV (output, 1, line valid), D_OUT (output, 16, pixel data).
REQ-009 SHALL have ports err_sof (output, 1, pulse), err_eol (output, 1, pulse), underflow (output, 1, sticky).

Function
REQ-010 SHALL accept a beat into the FIFO when s_axis_tvalid && s_axis_tready; s_axis_tready = FIFO not full, registered.
REQ-011 SHALL store {tuser, tlast, tdata} per FIFO entry; simultaneous push and pop when full SHALL NOT be allowed (tready low when full).
REQ-012 SHALL use states IDLE, RUN; H_TOTAL = H_B_PORCH+ACTIVE_PIX+H_F_PORCH, V_TOTAL = V_B_PORCH+ACTIVE_LINES+V_F_PORCH.
REQ-013 SHALL in IDLE pop and discard every FIFO head with tuser=0; a head with tuser=1 SHALL NOT be popped and SHALL move to RUN with h_cnt=0, v_cnt=0 next cycle.
REQ-014 SHALL in RUN increment h_cnt each cycle, wrap at H_TOTAL-1 to 0 and increment v_cnt; at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 SHALL return to IDLE.
REQ-015 SHALL define active row: V_B_PORCH <= v_cnt < V_B_PORCH+ACTIVE_LINES; active pixel: active row and H_B_PORCH <= h_cnt < H_B_PORCH+ACTIVE_PIX.
REQ-016 SHALL register outputs with 1-cycle latency: FV = active row, LV = active pixel, D_OUT = popped tdata when LV else 0.
REQ-017 SHALL pop exactly one FIFO entry per active pixel while not in underflow-frame mode.
REQ-018 SHALL pulse err_eol for one cycle when a popped beat has tlast mismatching (h_cnt == H_B_PORCH+ACTIVE_PIX-1).
REQ-019 SHALL pulse err_sof for one cycle when a popped beat has tuser=1 at any active pixel other than the first of the frame.
REQ-020 SHALL, if the FIFO is empty at an active pixel, set underflow, output D_OUT=0 for that and all remaining active pixels of the frame, stop popping, and keep FV/LV timing unchanged; resync occurs via IDLE.
REQ-021 SHALL keep underflow set until reset.

Reset
REQ-022 SHALL on resetn low asynchronously clear FIFO, state to IDLE, counters, FV=0, LV=0, D_OUT=0, err_sof=0, err_eol=0, underflow=0, s_axis_tready=0.
REQ-023 SHALL drive s_axis_tready=1 on the first pclk edge after resetn deasserts; reset mid-frame SHALL discard all buffered beats.

Configuration
REQ-024 SHALL with macro AXIS_ERR_CNT_EN defined add outputs sof_err_cnt and eol_err_cnt (16 bits each, saturating, reset 0) counting err_sof and err_eol pulses.
REQ-025 SHALL without AXIS_ERR_CNT_EN omit those ports and counters; all other behaviour identical.

Verification (bench params ACTIVE_PIX=4, ACTIVE_LINES=2, all porches=2, H_TOTAL=8, V_TOTAL=6)
REQ-026 SHALL cover: frame 0x0001..0x0008, tuser on first, tlast every 4th, tvalid always -> LV high 4 cycles per line, 2 lines, D_OUT 1..8 in order, no errors.
REQ-027 SHALL cover: 3 beats tuser=0 then valid frame -> 3 beats dropped in IDLE, output frame identical to REQ-026.
REQ-028 SHALL cover: tlast on 3rd pixel of line 0 -> err_eol pulses twice (pixel 3 early, pixel 4 missing), timing unchanged.
REQ-029 SHALL cover: tvalid held low after 5 beats -> underflow=1 at 6th active pixel, D_OUT=0 for pixels 6..8, FV/LV timing unchanged, next tuser frame outputs correctly.
REQ-030 SHALL cover: resetn low mid-line 1 -> FV, LV, D_OUT 0 immediately, tready 0; after release, tready 1 next edge, next tuser frame correct.
